part2: RTL and testbench

PART2 -- requirements
Module: part2

---
 rtl/part2_pkg.sv | 26 ++
 rtl/part2_crc8.sv | 32 +++
 rtl/part2.sv | 45 ++++
 tb/tb_part2.sv | 122 ++++++++++++
 4 files changed

// File: rtl/part2_pkg.sv
// CRC-8 shared definitions: default generator/seed constants and a
// reference byte-CRC function usable by both RTL and verification models.
package part2_pkg;

  localparam int unsigned CRC_W = 8;

  // Generator polynomial x^8 + x^2 + x + 1 (implicit x^8 term), MSB-first.
  localparam logic [CRC_W-1:0] DEF_POLY = 8'h07;
  // Register seed applied before every byte.
  localparam logic [CRC_W-1:0] DEF_INIT = 8'h00;

  // CRC-8 of a single byte: no reflection, no final XOR.
  function automatic logic [CRC_W-1:0] crc8_calc(
    input logic [CRC_W-1:0] data,
    input logic [CRC_W-1:0] seed,
    input logic [CRC_W-1:0] poly
  );
    logic [CRC_W-1:0] c;
    c = seed ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[CRC_W-1] ? (CRC_W'(c << 1) ^ poly) : CRC_W'(c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/part2_crc8.sv
// crc8_byte: purely combinational CRC-8 of one byte (unrolled 8-step shift/XOR).
// Ports:
//   data - input byte
//   seed - CRC register starting value
//   crc  - resulting CRC-8 (combinational)
module crc8_byte
  import part2_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEF_POLY
) (
  input  logic [CRC_W-1:0] data,
  input  logic [CRC_W-1:0] seed,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] c_c;

  // Fully unrolled by synthesis into an XOR network.
  always_comb begin
    c_c = seed ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c_c[CRC_W-1]) begin
        c_c = CRC_W'(c_c << 1) ^ POLY;
      end else begin
        c_c = CRC_W'(c_c << 1);
      end
    end
  end

  assign crc = c_c;

endmodule

// File: rtl/part2.sv
// part2: per-byte CRC-8 with a single output register. Every byte is
// independent; the only state is the y register (1-cycle latency, full rate).
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset, clears y to 8'h00
//   x     - data byte, sampled every cycle
//   y     - registered CRC-8 of the x sampled on the previous edge
module part2
  import part2_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEF_POLY,
  parameter logic [CRC_W-1:0] INIT = DEF_INIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CRC_W-1:0] x,
  output logic [CRC_W-1:0] y
);

  logic [CRC_W-1:0] crc_c;
  logic [CRC_W-1:0] y_d;
  logic [CRC_W-1:0] y_q;

  crc8_byte #(
    .POLY (POLY)
  ) u_crc8_byte (
    .data (x),
    .seed (INIT),
    .crc  (crc_c)
  );

  assign y_d = crc_c;

  // Output register; y is glitch-free between edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_part2.sv
// Scoreboard bench for part2: the driver pushes the expected y for each
// clock edge; an independent monitor pops and compares after every edge.
module tb_part2;

  logic       clk;
  logic       rst_n;
  logic [7:0] x;
  logic [7:0] y;

  int n_vec;
  int n_err;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  part2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model: remainder of x * x^8 modulo 0x107 (INIT = 0).
  function automatic logic [7:0] model_crc(input logic [7:0] b);
    logic [15:0] r;
    r = {b, 8'h00};
    for (int i = 15; i >= 8; i--) begin
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    end
    return r[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: y=%02h expected %02h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle on the falling edge; expected value is for the next rising edge.
  task automatic drive(input logic [7:0] xv, input logic rv, input logic [7:0] exp, input string tag);
    exp_t e;
    @(negedge clk);
    x     = xv;
    rst_n = rv;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: compare after every rising edge when an expectation is pending.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.tag, y, e.exp);
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    x     = 8'h00;

    // Reset held 3 cycles with x=AA, then release.
    for (int i = 0; i < 3; i++) drive(8'hAA, 1'b0, 8'h00, "reset_hold");
    drive(8'hAA, 1'b1, 8'h5F, "reset_release");

    // Held-value vectors with 1-cycle latency.
    for (int i = 0; i < 10; i++) drive(8'h00, 1'b1, 8'h00, "hold_00");
    for (int i = 0; i < 10; i++) drive(8'hAA, 1'b1, 8'h5F, "hold_AA");
    for (int i = 0; i < 10; i++) drive(8'hCC, 1'b1, 8'h6A, "hold_CC");

    // Single-bit and all-ones vectors.
    drive(8'h01, 1'b1, 8'h07, "x_01");
    drive(8'hFF, 1'b1, 8'hF3, "x_FF");

    // Full sweep at full throughput with a one-cycle reset pulse mid-stream.
    for (int i = 0; i < 256; i++) begin
      if (i == 100) drive(8'(i), 1'b0, 8'h00, "sweep_rst");
      else          drive(8'(i), 1'b1, model_crc(8'(i)), "sweep");
    end

    // Toggle x between edges: y must keep CRC(AA) until the next edge.
    drive(8'hAA, 1'b1, 8'h5F, "pre_glitch");
    @(negedge clk);
    x = 8'h12; #1; check("glitch_1", y, 8'h5F);
    x = 8'h34; #1; check("glitch_2", y, 8'h5F);
    x = 8'hFF; #1; check("glitch_3", y, 8'h5F);
    begin
      exp_t e;
      e.exp = 8'hF3;
      e.tag = "post_glitch";
      sb_q.push_back(e);
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
